// File: rtl/mant_mul_pkg.sv
// Shared constants and the tile pass predicate for the mantissa partial-product gate.
// The tile pass predicate is shared by the gating logic.
package mant_mul_pkg;

    localparam int TILE_W_DEF = 14;
    localparam int GRID_DEF   = 4;

    // Lane modes for GRID=4; larger op values select fewer, wider lanes.
    localparam int MODE_LANES_MAX  = 0;
    localparam int MODE_LANES_HALF = 1;
    localparam int MODE_LANE_ONE   = 2;

    // A tile survives when both of its coordinates fall inside the same 2^op-wide lane.
    function automatic logic tile_pass(input int unsigned i, input int unsigned j,
                                       input int unsigned op, input int unsigned grid_log2);
        if (op > grid_log2) begin
            return 1'b0;
        end
        return (i >> op) == (j >> op);
    endfunction

endpackage

// File: rtl/mant_pp_gate_comb.sv
// Combinational lane gating of the GRID x GRID tile array.
// Also produces the lane-start mask and the illegal-mode flag.
module mant_pp_gate_comb
    import mant_mul_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int GRID   = GRID_DEF,
    parameter int OP_W   = 2
) (
    input  logic [GRID*GRID*TILE_W-1:0] in_pp,
    input  logic [OP_W-1:0]             in_op,
    output logic [GRID*GRID*TILE_W-1:0] gated_pp,
    output logic [GRID-1:0]             lane_mask,
    output logic                        illegal
);

    localparam int unsigned LOG_G = $clog2(GRID);

    logic [31:0] op_u;

    assign op_u    = 32'(in_op);
    assign illegal = (op_u > LOG_G);

    always_comb begin
        gated_pp  = '0;
        lane_mask = '0;
        for (int i = 0; i < GRID; i++) begin
            for (int j = 0; j < GRID; j++) begin
                if (tile_pass(i, j, op_u, LOG_G)) begin
                    gated_pp[(i*GRID+j)*TILE_W +: TILE_W] = in_pp[(i*GRID+j)*TILE_W +: TILE_W];
                end
            end
        end
        // Row k starts a lane when it is a multiple of the lane height.
        for (int k = 0; k < GRID; k++) begin
            lane_mask[k] = !illegal && ((32'(k) & ((32'd1 << op_u) - 32'd1)) == 32'd0);
        end
    end

endmodule

// File: rtl/mant_pp_gate_pipe.sv
// Lane gate followed by a 2-entry valid/ready FIFO feeding the partial-product reduction stage.
module mant_pp_gate_pipe
    import mant_mul_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int GRID   = GRID_DEF,
    parameter int OP_W   = 2,
    parameter int TAG_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [GRID*GRID*TILE_W-1:0] in_pp,
    input  logic [OP_W-1:0]             in_op,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [GRID*GRID*TILE_W-1:0] out_pp,
    output logic [GRID-1:0]             out_lane_mask,
    output logic                        out_illegal,
    output logic [TAG_W-1:0]            out_tag
);

    localparam int PP_W    = GRID * GRID * TILE_W;
    localparam int ENTRY_W = PP_W + GRID + 1 + TAG_W;

    logic [PP_W-1:0]    gated_pp;
    logic [GRID-1:0]    lane_mask;
    logic               illegal;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;

    logic [ENTRY_W-1:0] mem_q [2];
    logic [ENTRY_W-1:0] mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               push, pop;

    mant_pp_gate_comb #(
        .TILE_W (TILE_W),
        .GRID   (GRID),
        .OP_W   (OP_W)
    ) u_gate (
        .in_pp     (in_pp),
        .in_op     (in_op),
        .gated_pp  (gated_pp),
        .lane_mask (lane_mask),
        .illegal   (illegal)
    );

    assign entry_in  = {in_tag, illegal, lane_mask, gated_pp};
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Outputs are forced to zero while empty so stale storage never leaks out.
    assign head = out_valid ? mem_q[rd_ptr_q] : '0;
    assign {out_tag, out_illegal, out_lane_mask, out_pp} = head;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = entry_in;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 2; e++) begin
                mem_q[e] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
